// File: rtl/logic_proc_pkg.sv
// rtl/logic_proc_pkg.sv - shared types for the bit-serial logic processor
package logic_proc_pkg;

  // Where the compute slice result bit is steered during a serial operation
  typedef enum logic [1:0] {
    ROUTE_HOLD   = 2'b00,
    ROUTE_F_TO_A = 2'b01,
    ROUTE_F_TO_B = 2'b10,
    ROUTE_SWAP   = 2'b11
  } route_t;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    HOLD  = 2'b10
  } state_t;

endpackage

// File: rtl/serial_shift_reg.sv
// rtl/serial_shift_reg.sv - parallel-load, shift-right operand register
module serial_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load,
  input  logic             Shift_En,
  input  logic             Shift_In,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Dout,
  output logic             Shift_Out
);

  logic [WIDTH-1:0] q;

  // Parallel load wins over shifting; shifting drops bit 0 and fills at the top
  always_ff @(posedge Clk) begin
    if (Reset) begin
      q <= '0;
    end else if (Load) begin
      q <= Din;
    end else if (Shift_En) begin
      q <= {Shift_In, q[WIDTH-1:1]};
    end
  end

  assign Dout      = q;
  assign Shift_Out = q[0];

endmodule

// File: rtl/serial_reg_unit.sv
// rtl/serial_reg_unit.sv - operand registers, result routing and serial sequencer
module serial_reg_unit #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LoadA,
  input  logic             LoadB,
  input  logic             Execute,
  input  logic [1:0]       R,
  input  logic [WIDTH-1:0] Din,
  input  logic             F_A_B,
  output logic             A_In,
  output logic             B_In,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done
);

  import logic_proc_pkg::*;

  localparam int CW = $clog2(WIDTH) + 1;

  state_t          state;
  route_t          r_q;
  logic [CW-1:0]   cnt;
  logic            busy_q;
  logic            done_q;
  logic            shift_en;
  logic            load_a;
  logic            load_b;
  logic            a_shift_in;
  logic            b_shift_in;

  // Loads are only honoured while idle; shifting only while in SHIFT
  assign load_a   = LoadA && (state == IDLE);
  assign load_b   = LoadB && (state == IDLE);
  assign shift_en = (state == SHIFT);

  // Steer the slice result or the outgoing operand bits back into the register tops
  always_comb begin
    a_shift_in = A_In;
    b_shift_in = B_In;
    case (r_q)
      ROUTE_HOLD:   begin a_shift_in = A_In;  b_shift_in = B_In;  end
      ROUTE_F_TO_A: begin a_shift_in = F_A_B; b_shift_in = B_In;  end
      ROUTE_F_TO_B: begin a_shift_in = A_In;  b_shift_in = F_A_B; end
      ROUTE_SWAP:   begin a_shift_in = B_In;  b_shift_in = A_In;  end
      default:      begin a_shift_in = A_In;  b_shift_in = B_In;  end
    endcase
  end

  serial_shift_reg #(.WIDTH(WIDTH)) u_reg_a (
    .Clk       (Clk),
    .Reset     (Reset),
    .Load      (load_a),
    .Shift_En  (shift_en),
    .Shift_In  (a_shift_in),
    .Din       (Din),
    .Dout      (A),
    .Shift_Out (A_In)
  );

  serial_shift_reg #(.WIDTH(WIDTH)) u_reg_b (
    .Clk       (Clk),
    .Reset     (Reset),
    .Load      (load_b),
    .Shift_En  (shift_en),
    .Shift_In  (b_shift_in),
    .Din       (Din),
    .Dout      (B),
    .Shift_Out (B_In)
  );

  // Sequencer: accept in IDLE, run WIDTH shifts, then hold until Execute drops
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      r_q    <= ROUTE_HOLD;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Execute) begin
            r_q    <= route_t'(R);
            cnt    <= '0;
            state  <= SHIFT;
            busy_q <= 1'b1;
          end
        end
        SHIFT: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state  <= HOLD;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        HOLD: begin
          if (!Execute) begin
            state  <= IDLE;
            done_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;

endmodule
